// File: rtl/axis_sa_y_serializer.sv
// Wide-to-narrow AXI-Stream serializer for systolic-array result beats: R words per beat out one per cycle, word 0 first.
// Optional beat-count length check (len_err port) is enabled with `define AXIS_YSER_LEN_CHECK_EN.
module axis_sa_y_serializer #(
  parameter int R     = 2,
  parameter int WY    = 17,
  parameter int BEATS = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [R*WY-1:0] s_data,
  input  logic [R-1:0]    s_keep,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [WY-1:0]   m_data,
  output logic            m_last
`ifdef AXIS_YSER_LEN_CHECK_EN
  ,
  output logic            len_err
`endif
);

  // Handshakes: a beat/word transfers on a rising clk edge where valid && ready;
  // a valid source holds its payload stable until that edge.
  localparam int IW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic {EMPTY = 1'b0, SEND = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [R*WY-1:0] buf_q, buf_d;
  logic            buf_last_q, buf_last_d;
  logic [IW-1:0]   lidx_q, lidx_d;
  logic [IW-1:0]   idx_q, idx_d, idx_n;
  logic            m_valid_d, m_last_d;
  logic [WY-1:0]   m_data_d;
  logic            ready_c, accept, at_last;
  logic [WY-1:0]   buf_w [R];

  // Index of the highest set keep bit; an all-zero keep still sends word 0.
  function automatic logic [IW-1:0] last_idx(input logic [R-1:0] keep);
    logic [IW-1:0] li;
    li = '0;
    for (int i = 0; i < R; i++)
      if (keep[i]) li = IW'(i);
    return li;
  endfunction

  always_comb begin
    for (int i = 0; i < R; i++) buf_w[i] = buf_q[i*WY +: WY];
  end

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_last_d = buf_last_q;
    lidx_d     = lidx_q;
    idx_d      = idx_q;
    m_valid_d  = m_valid;
    m_data_d   = m_data;
    m_last_d   = m_last;
    ready_c    = 1'b0;
    idx_n      = idx_q + 1'b1;
    at_last    = (idx_q == lidx_q);
    case (state_q)
      EMPTY: ready_c = 1'b1;
      SEND: begin
        if (m_valid && m_ready) begin
          if (!at_last) begin
            idx_d    = idx_n;
            m_data_d = buf_w[idx_n];
            m_last_d = buf_last_q && (idx_n == lidx_q);
          end else begin
            // Final word leaving: take the next beat in the same cycle to avoid a bubble.
            ready_c = 1'b1;
            if (!s_valid) begin
              state_d   = EMPTY;
              m_valid_d = 1'b0;
              m_last_d  = 1'b0;
            end
          end
        end
      end
      default: state_d = EMPTY;
    endcase
    accept = s_valid && ready_c;
    if (accept) begin
      state_d    = SEND;
      buf_d      = s_data;
      buf_last_d = s_last;
      lidx_d     = last_idx(s_keep);
      idx_d      = '0;
      m_valid_d  = 1'b1;
      m_data_d   = s_data[WY-1:0];
      m_last_d   = s_last && (last_idx(s_keep) == '0);
    end
  end

  assign s_ready = rstn && ready_c;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= EMPTY;
      buf_q      <= '0;
      buf_last_q <= 1'b0;
      lidx_q     <= '0;
      idx_q      <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_last_q <= buf_last_d;
      lidx_q     <= lidx_d;
      idx_q      <= idx_d;
      m_valid    <= m_valid_d;
      m_data     <= m_data_d;
      m_last     <= m_last_d;
    end
  end

`ifdef AXIS_YSER_LEN_CHECK_EN
  logic [15:0] cnt_q;
  logic        cnt_hit;

  assign cnt_hit = (int'(cnt_q) + 1) == BEATS;

  // Flags a last beat arriving early/late, or a packet running past BEATS without last.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q   <= '0;
      len_err <= 1'b0;
    end else begin
      len_err <= accept && (s_last ? !cnt_hit : cnt_hit);
      if (accept) cnt_q <= s_last ? '0 : cnt_q + 16'd1;
    end
  end
`else
  logic unused_beats;
  assign unused_beats = (BEATS != 0);
`endif

endmodule

// File: tb/tb_axis_sa_y_serializer.sv
// Self-checking bench for axis_sa_y_serializer: vector table, hand sequences for latency/no-bubble/reset,
// and randomized packets with backpressure checked against a word-queue model.
module tb_axis_sa_y_serializer;

  localparam int R     = 2;
  localparam int WY    = 17;
  localparam int BEATS = 2;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [R*WY-1:0] s_data = '0;
  logic [R-1:0]    s_keep = '0;
  logic            s_last = 1'b0;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [WY-1:0]   m_data;
  logic            m_last;
`ifdef AXIS_YSER_LEN_CHECK_EN
  logic            len_err;
`endif

  axis_sa_y_serializer #(.R(R), .WY(WY), .BEATS(BEATS)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_keep  (s_keep),
    .s_last  (s_last),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last)
`ifdef AXIS_YSER_LEN_CHECK_EN
    ,
    .len_err (len_err)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [WY:0] exp_q[$];   // {last, word}
  logic        mon_en = 1'b0;
  logic        drv_done = 1'b0;
  int          mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic          prev_stall = 1'b0;
  logic [WY-1:0] prev_data;
  logic          prev_last;
  logic [WY:0]   mon_e;

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
        chk("stall_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", m_valid, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("word_data", m_data, mon_e[WY-1:0]);
          chk("word_last", m_last, mon_e[WY]);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Called aligned 1 time unit after a rising edge; returns aligned the same way.
  task automatic send_packet(input int nbeats);
    logic [31:0] w;
    int          n;
    logic        hs;
    int          t;
    for (int b = 0; b < nbeats; b++) begin
      for (int i = 0; i < R; i++) begin
        w = $urandom;
        s_data[i*WY +: WY] = w[WY-1:0];
      end
      s_keep = R'($urandom_range(0, (1 << R) - 1));
      s_last = (b == nbeats - 1);
      n = (s_keep == 0) ? 1 : $clog2(int'(s_keep) + 1);
      for (int k = 0; k < n; k++)
        exp_q.push_back({s_last && (k == n - 1), s_data[k*WY +: WY]});
      s_valid = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        hs = s_ready;
        @(posedge clk); #1;
        t++;
      end while (!hs && t < 300);
      chk("beat_accepted", hs, 1);
      s_valid = 1'b0;
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [R*WY-1:0] data;
    logic [R-1:0]    keep;
    logic            last;
    int              n;
    logic [WY-1:0]   w0;
    logic [WY-1:0]   w1;
    logic            l0;
    logic            l1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [WY-1:0] ew;
    logic          el;
    int            pulses;

    vecs[0] = '{data: {17'd5, 17'd3},          keep: 2'b11, last: 1'b1, n: 2, w0: 17'd3,     w1: 17'd5,     l0: 1'b0, l1: 1'b1};
    vecs[1] = '{data: {17'h00AAA, 17'h1FFF9},  keep: 2'b01, last: 1'b1, n: 1, w0: 17'h1FFF9, w1: 17'h0,     l0: 1'b1, l1: 1'b0};
    vecs[2] = '{data: {17'h12345, 17'h0BEEF},  keep: 2'b00, last: 1'b1, n: 1, w0: 17'h0BEEF, w1: 17'h0,     l0: 1'b1, l1: 1'b0};
    vecs[3] = '{data: {17'h1FFFF, 17'h00000},  keep: 2'b10, last: 1'b1, n: 2, w0: 17'h00000, w1: 17'h1FFFF, l0: 1'b0, l1: 1'b1};
    vecs[4] = '{data: {17'd7, 17'd6},          keep: 2'b11, last: 1'b0, n: 2, w0: 17'd6,     w1: 17'd7,     l0: 1'b0, l1: 1'b0};
    vecs[5] = '{data: {17'd9, 17'd8},          keep: 2'b01, last: 1'b1, n: 1, w0: 17'd8,     w1: 17'h0,     l0: 1'b1, l1: 1'b0};

    // Reset state
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_s_ready", s_ready, 0);
`ifdef AXIS_YSER_LEN_CHECK_EN
    chk("rst_len_err", len_err, 0);
`endif
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    chk("idle_s_ready", s_ready, 1);
    chk("idle_m_valid", m_valid, 0);

    // Table: single beats, m_ready held high
    m_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_data  = vecs[v].data;
      s_keep  = vecs[v].keep;
      s_last  = vecs[v].last;
      @(negedge clk);
      chk("tbl_s_ready", s_ready, 1);
      @(posedge clk); #1;
      s_valid = 1'b0;
      for (int k = 0; k < vecs[v].n; k++) begin
        ew = (k == 0) ? vecs[v].w0 : vecs[v].w1;
        el = (k == 0) ? vecs[v].l0 : vecs[v].l1;
        @(negedge clk);
        chk("tbl_m_valid", m_valid, 1);
        chk("tbl_m_data", m_data, ew);
        chk("tbl_m_last", m_last, el);
        @(posedge clk);
      end
      @(negedge clk);
      chk("tbl_drained", m_valid, 0);
    end

    // Back-to-back 2-beat packet, no bubble
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = {17'd2, 17'd1}; s_keep = 2'b11; s_last = 1'b0;
    @(negedge clk); chk("b2b_ready0", s_ready, 1);
    @(posedge clk); #1;
    s_data = {17'd4, 17'd3}; s_last = 1'b1;
    @(negedge clk);
    chk("b2b_w1", m_data, 1); chk("b2b_l1", m_last, 0); chk("b2b_r1", s_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_w2", m_data, 2); chk("b2b_l2", m_last, 0); chk("b2b_r2", s_ready, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("b2b_v3", m_valid, 1); chk("b2b_w3", m_data, 3); chk("b2b_l3", m_last, 0); chk("b2b_r3", s_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_w4", m_data, 4); chk("b2b_l4", m_last, 1); chk("b2b_r4", s_ready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_empty", m_valid, 0);

    // Reset in the middle of a packet
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = {17'd2, 17'd1}; s_keep = 2'b11; s_last = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk); chk("mid_w1", m_data, 1);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk); chk("mid_rst_ready", s_ready, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_last", m_last, 0);
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = {17'd9, 17'd8}; s_keep = 2'b11; s_last = 1'b1;
    @(negedge clk); chk("post_rst_ready", s_ready, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("post_v1", m_valid, 1); chk("post_w1", m_data, 8); chk("post_l1", m_last, 0);
    @(posedge clk);
    @(negedge clk);
    chk("post_w2", m_data, 9); chk("post_l2", m_last, 1);
    @(posedge clk);
    @(negedge clk);
    chk("post_empty", m_valid, 0);

`ifdef AXIS_YSER_LEN_CHECK_EN
    // 3-beat packet: error after beat 2 and beat 3
    pulses = 0;
    @(posedge clk); #1;
    s_valid = 1'b1; s_keep = 2'b01;
    for (int b = 0; b < 3; b++) begin
      s_data = {17'd0, 17'(10 + b)};
      s_last = (b == 2);
      @(negedge clk);
      if (len_err) pulses++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    repeat (4) begin @(negedge clk); if (len_err) pulses++; end
    chk("len_err_3beat", pulses, 2);
    // 2-beat packet: no error
    pulses = 0;
    @(posedge clk); #1;
    s_valid = 1'b1; s_keep = 2'b01;
    for (int b = 0; b < 2; b++) begin
      s_data = {17'd0, 17'(20 + b)};
      s_last = (b == 1);
      @(negedge clk);
      if (len_err) pulses++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    repeat (4) begin @(negedge clk); if (len_err) pulses++; end
    chk("len_err_2beat", pulses, 0);
`endif

    // Randomized packets against the word-queue model
    do_reset();
    mon_en = 1'b1;
    @(posedge clk); #1;
    fork
      begin
        mode = 0;
        for (int p = 0; p < 4; p++) send_packet(2);
        mode = 1;
        for (int p = 0; p < 40; p++) send_packet($urandom_range(1, 3));
        drv_done = 1'b1;
      end
      begin
        int cyc;
        cyc = 0;
        while (!drv_done) begin
          m_ready = (mode == 0) ? (cyc % 3 == 0) : ($urandom_range(0, 3) != 0);
          cyc++;
          @(posedge clk); #1;
        end
      end
    join
    m_ready = 1'b1;
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_m_valid", m_valid, 0);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
